// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and (with HAZARD_MC_EN defined) a multicycle-execute stall FSM.
module hazard_ctrl_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic [REG_AW-1:0]         RD_M,
    input  logic [REG_AW-1:0]         RD_W,
    input  logic [REG_AW-1:0]         RD_E,
    input  logic                      MemReadE,
    input  logic [NUM_SRC*REG_AW-1:0] Rs_E,
    input  logic [NUM_SRC*REG_AW-1:0] Rs_D,
    input  logic                      PCSrcE,
    input  logic                      McStartE,
    output logic [2*NUM_SRC-1:0]      Forward_E,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      McBusy,
    output logic                      McDone
);

    localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

    logic [2*NUM_SRC-1:0] fwd_s;
    logic                 lw_stall_s;
    logic                 mc_stall_s;
    logic                 mc_busy_s;
    logic                 mc_done_s;

    // Per-slot forwarding select (M beats W, x0 never forwarded) and load-use detect
    always_comb begin
        fwd_s      = {(2*NUM_SRC){1'b0}};
        lw_stall_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RegWriteM && (RD_M != REG_X0) && (RD_M == Rs_E[i*REG_AW +: REG_AW])) begin
                fwd_s[2*i +: 2] = 2'b10;
            end else if (RegWriteW && (RD_W != REG_X0) && (RD_W == Rs_E[i*REG_AW +: REG_AW])) begin
                fwd_s[2*i +: 2] = 2'b01;
            end else begin
                fwd_s[2*i +: 2] = 2'b00;
            end
            if (MemReadE && (RD_E != REG_X0) && (RD_E == Rs_D[i*REG_AW +: REG_AW])) begin
                lw_stall_s = 1'b1;
            end else begin
                lw_stall_s = lw_stall_s;
            end
        end
    end

`ifdef HAZARD_MC_EN
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Multicycle FSM state and countdown register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; McStartE is ignored in BUSY since the held op keeps it asserted
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_s = 1'b0;
        mc_done_s  = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (McStartE) begin
                    mc_stall_s = 1'b1;
                    cnt_d      = CNT_LOAD;
                    state_d    = MC_BUSY;
                end else begin
                    state_d    = MC_IDLE;
                end
            end
            MC_BUSY: begin
                if (cnt_q != CNT_ZERO) begin
                    mc_stall_s = 1'b1;
                    cnt_d      = cnt_q - CNT_ONE;
                end else begin
                    mc_done_s  = 1'b1;
                    state_d    = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign mc_busy_s = (state_q == MC_BUSY);
`else
    logic unused_mc_s;

    assign unused_mc_s = McStartE ^ clk;
    assign mc_stall_s  = 1'b0;
    assign mc_busy_s   = 1'b0;
    assign mc_done_s   = 1'b0;
`endif

    // Output decode, forced to zero combinationally while reset is asserted
    always_comb begin
        if (!rst) begin
            Forward_E = {(2*NUM_SRC){1'b0}};
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
            McBusy    = 1'b0;
            McDone    = 1'b0;
        end else begin
            Forward_E = fwd_s;
            StallF    = (lw_stall_s | mc_stall_s) & ~PCSrcE;
            StallD    = (lw_stall_s | mc_stall_s) & ~PCSrcE;
            StallE    = mc_stall_s;
            FlushD    = PCSrcE;
            // A held E stage must never be bubbled
            FlushE    = PCSrcE | (lw_stall_s & ~mc_stall_s);
            FlushM    = mc_stall_s;
            McBusy    = mc_busy_s;
            McDone    = mc_done_s;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit (NUM_SRC=3, MC_LAT=4); covers both
// HAZARD_MC_EN builds by carrying expectations for each.
module tb_hazard_ctrl_unit;

    localparam int NS = 3;
    localparam int AW = 5;
`ifdef HAZARD_MC_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteM, RegWriteW, MemReadE, PCSrcE, McStartE;
    logic [AW-1:0]   RD_M, RD_W, RD_E;
    logic [NS*AW-1:0] Rs_E, Rs_D;
    logic [2*NS-1:0] Forward_E;
    logic            StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone;

    int checks   = 0;
    int failures = 0;

    // expected vector: {Forward_E[5:0], StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone}
    logic [13:0] exp_q[$];
    string       tag_q[$];

    hazard_ctrl_unit #(.NUM_SRC(NS), .REG_AW(AW), .MC_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E),
        .MemReadE(MemReadE), .Rs_E(Rs_E), .Rs_D(Rs_D),
        .PCSrcE(PCSrcE), .McStartE(McStartE),
        .Forward_E(Forward_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McBusy(McBusy), .McDone(McDone)
    );

    always #5 clk = ~clk;

    // Push the expectation, compare at the falling edge, then advance to just past the next rising edge
    task automatic cyc(input string tag, input logic [13:0] exp_en, input logic [13:0] exp_dis);
        logic [13:0] obs;
        logic [13:0] e;
        string       t;
        exp_q.push_back(MC ? exp_en : exp_dis);
        tag_q.push_back(tag);
        @(negedge clk);
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {Forward_E, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone};
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0;
        RD_M = 5'd0; RD_W = 5'd0; RD_E = 5'd0;
        Rs_E = {NS*AW{1'b0}}; Rs_D = {NS*AW{1'b0}};
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        // reset gating: hazards present but outputs must stay 0
        RegWriteM = 1'b1; RD_M = 5'd5; Rs_E = {5'd5, 5'd5, 5'd5}; PCSrcE = 1'b1; McStartE = 1'b1;
        MemReadE = 1'b1; RD_E = 5'd5; Rs_D = {5'd0, 5'd5, 5'd0};
        cyc("reset_gate", 14'b0, 14'b0);
        clear_inputs();
        rst = 1'b1;
        cyc("idle_after_reset", 14'b0, 14'b0);

        RegWriteM = 1'b1; RegWriteW = 1'b1; RD_M = 5'd5; RD_W = 5'd5;
        Rs_E = {5'd5, 5'd5, 5'd0};
        cyc("fwd_m_priority", {6'b101000, 8'b0}, {6'b101000, 8'b0});
        RegWriteM = 1'b0;
        cyc("fwd_w_only", {6'b010100, 8'b0}, {6'b010100, 8'b0});
        RegWriteM = 1'b1; RD_M = 5'd3; RD_W = 5'd4; Rs_E = {5'd4, 5'd3, 5'd9};
        cyc("fwd_mixed", {6'b011000, 8'b0}, {6'b011000, 8'b0});
        RD_M = 5'd0; RD_W = 5'd0; Rs_E = {5'd0, 5'd0, 5'd0};
        cyc("fwd_x0", 14'b0, 14'b0);
        clear_inputs();

        MemReadE = 1'b1; RD_E = 5'd7; Rs_D = {5'd0, 5'd7, 5'd0};
        cyc("lw_stall", {6'b0, 8'b11001000}, {6'b0, 8'b11001000});
        PCSrcE = 1'b1;
        cyc("lw_with_branch", {6'b0, 8'b00011000}, {6'b0, 8'b00011000});
        PCSrcE = 1'b0; RD_E = 5'd0; Rs_D = {5'd0, 5'd0, 5'd0};
        cyc("lw_x0", 14'b0, 14'b0);
        MemReadE = 1'b0; RD_E = 5'd7; Rs_D = {5'd7, 5'd0, 5'd0};
        cyc("no_load", 14'b0, 14'b0);
        MemReadE = 1'b1;
        cyc("lw_slot2", {6'b0, 8'b11001000}, {6'b0, 8'b11001000});
        clear_inputs();
        PCSrcE = 1'b1;
        cyc("branch_only", {6'b0, 8'b00011000}, {6'b0, 8'b00011000});
        clear_inputs();

        // multicycle op held in E from t
        McStartE = 1'b1;
        cyc("mc_t0", {6'b0, 8'b11100100}, 14'b0);
        cyc("mc_t1", {6'b0, 8'b11100110}, 14'b0);
        cyc("mc_t2", {6'b0, 8'b11100110}, 14'b0);
        cyc("mc_t3_done", {6'b0, 8'b00000011}, 14'b0);
        cyc("mc_b2b_t0", {6'b0, 8'b11100100}, 14'b0);
        MemReadE = 1'b1; RD_E = 5'd7; Rs_D = {5'd0, 5'd0, 5'd7};
        cyc("mc_lw_overlap", {6'b0, 8'b11100110}, {6'b0, 8'b11001000});
        MemReadE = 1'b0; PCSrcE = 1'b1;
        cyc("mc_branch", {6'b0, 8'b00111110}, {6'b0, 8'b00011000});
        PCSrcE = 1'b0; MemReadE = 1'b1;
        cyc("mc_done_lw", {6'b0, 8'b11001011}, {6'b0, 8'b11001000});
        clear_inputs();
        cyc("mc_back_idle", 14'b0, 14'b0);

        // reset in the middle of a sequence
        McStartE = 1'b1;
        cyc("rst_mid_t0", {6'b0, 8'b11100100}, 14'b0);
        rst = 1'b0;
        cyc("rst_mid_t1", 14'b0, 14'b0);
        rst = 1'b1; McStartE = 1'b0;
        cyc("after_rst_a", 14'b0, 14'b0);
        cyc("after_rst_b", 14'b0, 14'b0);
        cyc("after_rst_c", 14'b0, 14'b0);

        // long McStartE assertion with forwarding alongside
        McStartE = 1'b1; RegWriteW = 1'b1; RD_W = 5'd2; Rs_E = {5'd0, 5'd2, 5'd0};
        cyc("long_mc_0", {6'b000100, 8'b11100100}, {6'b000100, 8'b0});
        cyc("long_mc_1", {6'b000100, 8'b11100110}, {6'b000100, 8'b0});
        cyc("long_mc_2", {6'b000100, 8'b11100110}, {6'b000100, 8'b0});
        cyc("long_mc_3", {6'b000100, 8'b00000011}, {6'b000100, 8'b0});
        cyc("long_mc_4", {6'b000100, 8'b11100100}, {6'b000100, 8'b0});
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
